pio_poll_master: RTL
====================

Name: pio_poll_master

Overview:
Avalon-MM initiator that periodically reads a single-register PIO input responder, such as the 1-bit accumulate-button PIO, so that hardware can consume the input without Nios software polling. It issues fixed-latency reads, holds the last sampled word, and detects 0->1 transitions on bit 0. It also keeps a saturating event count. It sits in the SoC fabric beside the PIO and drives downstream datapath logic, for example the accumulate trigger of the lab adder.

Parameters:
ADDR_W, 2, width of the address output
POLL_ADDR, 0, word address read on every poll
DATA_W, 32, readdata and sample width
READ_LATENCY, 1, cycles from the read cycle to valid readdata; legal range 1..4
POLL_INTERVAL, 16, cycles between successive read assertions; must be >= READ_LATENCY+2
CNT_W, 16, width of rise_count

Ports:
clk  in  1  system clock; all logic on the rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  polling enable, level sensitive
clr_count  in  1  synchronous clear of rise_count
address  out  ADDR_W  Avalon address; constant POLL_ADDR
read  out  1  Avalon read strobe
readdata  in  DATA_W  Avalon read data from the responder
sample  out  DATA_W  last captured readdata
sample_valid  out  1  one-cycle pulse when sample updates
rise_pulse  out  1  one-cycle pulse: bit 0 went 0->1 between consecutive samples
rise_count  out  CNT_W  number of detected rises, saturating

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE.
  - read, sample, sample_valid, rise_pulse and rise_count are all 0.
  - The interval counter and latency counter are cleared.
  - The first_sample flag is set.
  - address is POLL_ADDR at all times, including during reset.
- Reset asserted mid-operation: any in-flight read is abandoned, no capture occurs, and the state is as above.
- FSM states: IDLE, READ, LAT, CAP, WAIT.
  - IDLE: if enable is 1 at an edge, go to READ, so read rises in the next cycle.
  - READ: read=1 for exactly one cycle, then go to LAT. The interval counter is loaded with POLL_INTERVAL-1 and decrements in every later cycle.
  - LAT: stays for READ_LATENCY-1 cycles (zero cycles when READ_LATENCY=1, going directly to CAP).
  - CAP: this cycle is T+READ_LATENCY, where T is the read cycle. At its closing edge, sample <= readdata. Go to WAIT.
  - WAIT: when the interval counter reaches 0 and enable=1, go to READ. Read cycles are therefore spaced exactly POLL_INTERVAL cycles apart. If enable=0 at that point, go to IDLE.
- Enable deasserted during READ, LAT or CAP: the read completes and is captured normally. No new read is issued afterwards.
- read is never asserted outside the READ state. It never lasts more than one cycle and there are no back-to-back reads.
- sample_valid: high for one cycle, the cycle after the capture edge (T+READ_LATENCY+1).
- rise_pulse: asserted in the same cycle as sample_valid when new sample[0]=1, old sample[0]=0, and first_sample=0.
  - The first capture after reset never produces a rise and clears first_sample.
  - Enable toggling does not reset the history.
- rise_count:
  - Increments by 1 in the cycle rise_pulse is high.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_count=1 alone gives 0 next cycle.
  - clr_count=1 in the same cycle as rise_pulse gives 1, so the event is not lost.
- sample holds its value while idle. It changes only at capture edges.

Test Plan:
- Reset release, enable=1, READ_LATENCY=1, POLL_INTERVAL=16, responder returns 0 -> read pulses at cycles 1, 17, 33; sample_valid at 3, 19, 35; sample=0; rise_count=0.
- Bit 0 of readdata 0 for the first poll, 1 from the second poll on -> single rise_pulse coinciding with the second sample_valid; rise_count=1; no further rises while bit 0 stays 1.
- readdata bit 0 =1 at the first poll after reset -> sample=1, no rise_pulse, rise_count=0.
- READ_LATENCY=3; responder drives 32'hA5 only in cycle T+3 and 32'h0 otherwise -> sample=32'hA5.
- enable dropped the cycle after read -> capture still occurs, no further read pulses; re-enable -> read in the cycle after enable is sampled high, and history is preserved.
- CNT_W=2 with 5 rises -> rise_count saturates at 3; clr_count coincident with a rise -> rise_count=1.
- reset_n pulsed low during LAT -> all outputs 0 immediately, no sample_valid afterwards, and polling restarts from IDLE once reset_n is released.

Source files
------------

// File: rtl/pio_poll_master.sv
// pio_poll_master: periodic Avalon-MM poller of a PIO register with bit-0 rise detection and a saturating event count
module pio_poll_master #(
  parameter int ADDR_W        = 2,
  parameter int POLL_ADDR     = 0,
  parameter int DATA_W        = 32,
  parameter int READ_LATENCY  = 1,
  parameter int POLL_INTERVAL = 16,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clr_count,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              rise_pulse,
  output logic [CNT_W-1:0]  rise_count
);
  localparam int IW = $clog2(POLL_INTERVAL);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LAT, S_CAP, S_WAIT} state_t;
  state_t state;
  logic [IW-1:0] ivl;
  logic [1:0] lat;
  logic first;
  assign address = ADDR_W'(POLL_ADDR);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      read <= 1'b0;
      sample <= '0;
      sample_valid <= 1'b0;
      rise_pulse <= 1'b0;
      rise_count <= '0;
      ivl <= '0;
      lat <= '0;
      first <= 1'b1;
    end else begin
      sample_valid <= 1'b0;
      rise_pulse <= 1'b0;
      if (ivl != '0) ivl <= ivl - IW'(1);
      // a rise coinciding with a clear is kept so the event is not lost
      rise_count <= clr_count ? CNT_W'(rise_pulse)
                              : rise_count + CNT_W'(rise_pulse && rise_count != '1);
      case (state)
        S_IDLE: if (enable) begin
          state <= S_READ;
          read <= 1'b1;
          ivl <= IW'(POLL_INTERVAL - 1);
        end
        S_READ: begin
          read <= 1'b0;
          lat <= 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
          state <= READ_LATENCY > 1 ? S_LAT : S_CAP;
        end
        S_LAT: begin
          if (lat == 2'd0) state <= S_CAP;
          else lat <= lat - 2'd1;
        end
        S_CAP: begin
          sample <= readdata;
          sample_valid <= 1'b1;
          rise_pulse <= !first && readdata[0] && !sample[0];
          first <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: if (ivl == '0) begin
          state <= enable ? S_READ : S_IDLE;
          read <= enable;
          if (enable) ivl <= IW'(POLL_INTERVAL - 1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
